// File: rtl/final555_pkg.sv
// Shared widths for the final555 select-match block.
package final555_pkg;
  localparam int SEL_W = 2;
  localparam int DEC_W = 4;
endpackage

// File: rtl/final555_decoder_2x4.sv
// 2-to-4 one-hot decoder; all outputs are low while en is low.
import final555_pkg::*;

module decoder_2x4 (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [DEC_W-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/final555.sv
// Registered equality flag for two 2-bit select words, built from two one-hot decoders.
import final555_pkg::*;

module final555 (
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic d,
  input  logic c1,
  input  logic d1,
  input  logic en,
  output logic f
);

  logic [DEC_W-1:0] da;
  logic [DEC_W-1:0] db;
  logic             m;

  decoder_2x4 u_dec_a (
    .sel ({d, c}),
    .en  (en),
    .dec (da)
  );

  decoder_2x4 u_dec_b (
    .sel ({d1, c1}),
    .en  (en),
    .dec (db)
  );

  // Overlapping one-hot bits means the selects are equal and en is high.
  assign m = |(da & db);

  always_ff @(posedge clk) begin
    if (rst) f <= 1'b0;
    else     f <= m;
  end

endmodule

// File: tb/tb_final555.sv
// Directed self-checking bench for final555.
module tb_final555;

  logic clk;
  logic rst;
  logic c, d, c1, d1, en;
  logic f;

  int checks;
  int failures;

  final555 dut (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .d   (d),
    .c1  (c1),
    .d1  (d1),
    .en  (en),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (f === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, f, exp);
    end
  endtask

  // Drive on the falling edge, confirm f holds its old value before the
  // rising edge, then confirm the registered result just after it.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic ic, input logic id, input logic ic1,
                      input logic id1, input logic exp_hold, input logic exp);
    @(negedge clk);
    rst = r; en = e; c = ic; d = id; c1 = ic1; d1 = id1;
    #2;
    check({tag, "_hold"}, exp_hold);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  logic [15:0] sweep_exp;
  logic        prev;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b1; c = 1'b0; d = 1'b0; c1 = 1'b0; d1 = 1'b0;
    @(posedge clk);
    #1;
    check("reset_initial", 1'b0);

    // Reset held for two cycles with a matching, enabled input pattern.
    step("reset_cyc1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset_cyc2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("idle_en0_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_en0_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    step("match_00",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("nomatch_10", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sweep with c fastest: A=i[1:0], B=i[3:2]; equal at 0, 5, 10, 15.
    sweep_exp = 16'b1000_0100_0010_0001;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step($sformatf("sweep_%0d", i), 1'b0, 1'b1, v[0], v[1], v[2], v[3],
           prev, sweep_exp[i]);
      prev = sweep_exp[i];
    end

    step("match_33",   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("en_drop_33", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // A=B=2 with f high, then a one-cycle reset that must override the match.
    step("match_22",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rst_pri_22", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("post_rst_22",1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("mismatch_21",1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
